// File: rtl/reg_serializer_64_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_ser_pkg
// Description : Shared types and constants for the reg_serializer_64 slice:
//               FSM state encoding, default word width, counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_ser_pkg;

    // Default parallel word width.
    localparam int DEFAULT_WIDTH = 64;

    // Serializer states. PARITY is only entered when SER_PARITY_EN is defined.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } ser_state_e;

    // Bit counter width: must represent 0..width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage : reg_ser_pkg
`default_nettype wire

// File: rtl/reg_serializer_64_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_serializer_64_if
// Description : Load handshake, serial stream and status signals of the
//               64-bit register serializer. The slave modport is the
//               serializer; the master modport is its upstream/downstream.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_serializer_64_if
    import reg_ser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_ready;
    logic             ser_last;
    logic             busy;
    logic             done;

    modport master (
        output data_in,
        output load_valid,
        output ser_ready,
        input  load_ready,
        input  ser_out,
        input  ser_valid,
        input  ser_last,
        input  busy,
        input  done
    );

    modport slave (
        input  data_in,
        input  load_valid,
        input  ser_ready,
        output load_ready,
        output ser_out,
        output ser_valid,
        output ser_last,
        output busy,
        output done
    );

endinterface : reg_serializer_64_if
`default_nettype wire

// File: rtl/reg_serializer_64_counter.sv
`default_nettype none
// ============================================================================
// Module      : ser_bit_counter
// Description : Beat counter for the serializer. Synchronous clear has
//               priority over enable; tc flags count == TERM.
// Revision    : 1.0 - initial release
// ============================================================================
module ser_bit_counter #(
    parameter int CNT_W = 7,
    parameter int TERM  = 63
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise step on enable.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
    assign tc    = (cnt_q == CNT_W'(TERM));

endmodule : ser_bit_counter
`default_nettype wire

// File: rtl/reg_serializer_64.sv
`default_nettype none
// ============================================================================
// Module      : reg_serializer_64
// Description : Accepts a parallel word on a valid/ready load handshake and
//               shifts it out one bit per accepted beat on a serial
//               valid/ready stream. All outputs are registered.
//               Optional macro SER_PARITY_EN appends an even-parity beat.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_serializer_64
    import reg_ser_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    reg_serializer_64_if.slave bus
);

    localparam int c_CNT_W = cnt_width(WIDTH);
`ifndef SER_PARITY_EN
    // Counter value one beat before the last data beat.
    localparam logic [c_CNT_W-1:0] c_PRE_TERM = c_CNT_W'(WIDTH - 2);
`endif

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             ser_last_q, ser_last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             load_ready_q, load_ready_d;
`ifdef SER_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic [WIDTH-1:0]   w_shifted;
    logic               w_load;
    logic               w_accept;
    logic               w_cnt_clr;
    logic               w_cnt_en;
    logic               w_cnt_tc;
    logic [c_CNT_W-1:0] w_cnt;

    // Bit presented at the output end of a shift-register value.
    function automatic logic out_bit(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    // Shift direction is toward the output end.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shifted = {sr_q[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_shifted = {1'b0, sr_q[WIDTH-1:1]};
        end
    endgenerate

    assign w_load   = bus.load_valid && load_ready_q;
    assign w_accept = ser_valid_q && bus.ser_ready;

    ser_bit_counter #(
        .CNT_W (c_CNT_W),
        .TERM  (WIDTH - 1)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_cnt_clr),
        .en    (w_cnt_en),
        .count (w_cnt),
        .tc    (w_cnt_tc)
    );

    // Next-state and next-output computation for the serializer FSM.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        ser_last_d = ser_last_q;
        done_d     = 1'b0;
        w_cnt_clr  = 1'b0;
        w_cnt_en   = 1'b0;
`ifdef SER_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (w_load) begin
                    state_d    = SHIFT;
                    sr_d       = bus.data_in;
                    w_cnt_clr  = 1'b1;
                    ser_last_d = 1'b0;
`ifdef SER_PARITY_EN
                    // Parity taken from the word as loaded, not the shifter.
                    parity_d   = ^bus.data_in;
`endif
                end
            end
            SHIFT: begin
                if (w_accept) begin
                    sr_d     = w_shifted;
                    w_cnt_en = 1'b1;
                    if (w_cnt_tc) begin
`ifdef SER_PARITY_EN
                        state_d    = PARITY;
                        ser_last_d = 1'b1;
`else
                        state_d    = IDLE;
                        done_d     = 1'b1;
                        ser_last_d = 1'b0;
`endif
                    end else begin
`ifdef SER_PARITY_EN
                        ser_last_d = 1'b0;
`else
                        ser_last_d = (w_cnt == c_PRE_TERM);
`endif
                    end
                end
            end
`ifdef SER_PARITY_EN
            PARITY: begin
                if (w_accept) begin
                    state_d    = IDLE;
                    done_d     = 1'b1;
                    ser_last_d = 1'b0;
                end
            end
`endif
            default: begin
                state_d    = IDLE;
                ser_last_d = 1'b0;
            end
        endcase

        ser_valid_d  = (state_d != IDLE);
        busy_d       = (state_d != IDLE);
        load_ready_d = (state_d == IDLE);
        ser_out_d    = out_bit(sr_d);
`ifdef SER_PARITY_EN
        if (state_d == PARITY) begin
            ser_out_d = parity_d;
        end
`endif
    end

    // State and registered outputs, asynchronous reset to idle values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sr_q         <= '0;
            ser_out_q    <= 1'b0;
            ser_valid_q  <= 1'b0;
            ser_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            load_ready_q <= 1'b1;
`ifdef SER_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            ser_out_q    <= ser_out_d;
            ser_valid_q  <= ser_valid_d;
            ser_last_q   <= ser_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            load_ready_q <= load_ready_d;
`ifdef SER_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    assign bus.ser_out    = ser_out_q;
    assign bus.ser_valid  = ser_valid_q;
    assign bus.ser_last   = ser_last_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.load_ready = load_ready_q;

endmodule : reg_serializer_64
`default_nettype wire

// File: doc/reg_serializer_64.md
Name: reg_serializer_64

Overview:
- Reader side of the 64-bit asynchronous-reset register.
- Accepts a 64-bit parallel word through a valid/ready load handshake and shifts it out one bit per accepted beat on a serial valid/ready stream.
- Sits between a 64-bit register and a narrow serial link or debug readback path.
- Single clock domain; asynchronous active-high reset.

Parameters:
- WIDTH, 64, parallel word width in bits; must be at least 2.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  WIDTH  parallel word; sampled only on a load handshake.
- load_valid  input  1  upstream offers data_in.
- load_ready  output  1  block can accept a word (high only in IDLE).
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out is valid.
- ser_ready  input  1  downstream accepts the current bit.
- ser_last  output  1  current beat is the final beat of the word.
- busy  output  1  a word is in flight.
- done  output  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset (async, takes effect immediately, independent of clk):
  - state = IDLE; shift register = 0; bit counter = 0.
  - load_ready = 1, ser_out = 0, ser_valid = 0, ser_last = 0, busy = 0, done = 0.
- States are IDLE, SHIFT, and PARITY (PARITY exists only with the optional feature).
- IDLE:
  - load_ready = 1.
  - On load_valid && load_ready: capture data_in into the shift register, clear the counter, go to SHIFT.
  - Without a handshake: hold state, ser_valid = 0.
- Load-to-first-bit latency: ser_valid goes high the cycle after the load handshake.
- SHIFT:
  - ser_valid = 1, busy = 1, load_ready = 0.
  - ser_out = shift-register MSB when MSB_FIRST=1, LSB otherwise.
  - A beat is accepted when ser_valid && ser_ready. On acceptance, shift by one toward the output end and increment the counter.
  - While ser_ready = 0, ser_out, ser_last and the counter hold; stalls of any length are allowed.
- Last beat:
  - ser_last = 1 when the counter equals WIDTH-1 (or on the PARITY beat when that feature is compiled in).
  - When the last beat is accepted: go to IDLE; done = 1 for exactly the next cycle; load_ready = 1 in that same cycle.
- Back-to-back words: load_valid asserted in the done cycle is accepted. The minimum gap between the last beat of one word and the first beat of the next is one cycle.
- load_valid while busy is ignored; data_in is not sampled and the upstream holds its word.
- Counter width is clog2(WIDTH+1). No wrap-around occurs, because the terminal count returns the FSM to IDLE.
- Reset mid-word: the word in flight is discarded, with no done pulse and no partial ser_last. All outputs go to reset values.
- The output bit order for a word is fixed at load; changing data_in while busy has no effect.

Optional Feature:
- Macro: SER_PARITY_EN.
- Defined:
  - After the WIDTH data beats, a PARITY state emits one extra beat carrying the even parity (XOR) of the captured word.
  - ser_last is asserted on the parity beat only; a word is WIDTH+1 beats.
  - Parity is computed from the word at load time, not from the shifting register.
- Undefined:
  - The PARITY state and parity logic do not exist; a word is WIDTH beats and ser_last is on data bit WIDTH-1.

Decomposition:
- Shared package reg_ser_pkg contains:
  - the state enum type (IDLE, SHIFT, PARITY);
  - the default width constant (64);
  - a counter-width constant/function (clog2(WIDTH+1)).
- One natural sub-module, ser_bit_counter:
  - clear/enable inputs and a terminal-count output;
  - asynchronous active-high reset on rst.
- Shift register and FSM stay in the top module.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then release, load_valid=0 → load_ready=1, ser_valid=0, busy=0, done=0 throughout.
- Basic MSB-first word: load 64'h8000_0000_0000_0001 with ser_ready=1 constantly → ser_out = 1 on beat 0, 0 on beats 1–62, 1 on beat 63; ser_last only on beat 63; done pulses one cycle later.
- Backpressure: load 64'hA5A5_A5A5_A5A5_A5A5 and drop ser_ready for 3 cycles at beats 0, 17 and 63 → ser_out and ser_last are stable during each stall; the stream still equals the word exactly (no lost or duplicated bits).
- Back-to-back: load 64'd35, and hold load_valid with 64'd55 on data_in during the done cycle → 55 is accepted in that cycle; its first bit is valid on the next cycle.
- Reset mid-word: load 64'hFFFF_FFFF_FFFF_FFFF and assert rst asynchronously (between edges) after 10 beats → outputs go to reset values immediately, with no done pulse; a following load of 64'd1 serializes correctly.
- SER_PARITY_EN defined: load 64'h7 → 65 beats; beat 64 carries 1 with ser_last=1. Load 64'h3 → parity beat = 0.
